inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage: owns the program counter, drives the address and chip-enable of the combinational instruction ROM, and captures each returned instruction word with its PC into a 2-entry prefetch buffer. Presents buffered {pc, inst} pairs to the decode stage over a valid/ready handshake. Accepts branch redirects and pipeline flushes that discard buffered instructions and restart fetch.

## Interface
Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset
- BUF_DEPTH, 2, prefetch buffer entries (fixed at 2; count is 2 bits)

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (asserted = 0)
- rom_ce_o  output  1  ROM chip enable; 1 = fetch active
- rom_addr_o  output  32  byte address to ROM (current PC)
- rom_inst_i  input  32  instruction returned combinationally for rom_addr_o
- branch_flag_i  input  1  redirect request from execute
- branch_target_i  input  32  redirect target
- flush_i  input  1  exception/flush request from control
- flush_pc_i  input  32  handler address for flush
- id_valid_o  output  1  head entry valid toward decode
- id_ready_i  input  1  decode accepts head this cycle
- id_pc_o  output  32  PC of head entry
- id_inst_o  output  32  instruction of head entry
- id_misalign_o  output  1  head entry is a misaligned-fetch marker (only with FETCH_MISALIGN_EN)

## Operation
- Registers: pc (32), ce (1), buffer[2] of {pc, inst, misalign}, rd_ptr, wr_ptr (1 bit each), count (0..2), halted (1, misalign option only).
- rom_addr_o = pc; rom_ce_o = ce. ROM data is valid in the same cycle.
- Enqueue condition: ce=1, no redirect/flush this cycle, halted=0, and (count<2 or dequeue this cycle). On enqueue: buffer[wr_ptr] <= {pc, rom_inst_i, 0}, wr_ptr++, pc <= pc+4.
- Dequeue: id_valid_o && id_ready_i; rd_ptr++.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither.
- Redirect priority: flush_i > branch_flag_i > normal fetch. On flush or branch: count, rd_ptr, wr_ptr <= 0; pc <= flush_pc_i or branch_target_i; no enqueue and no dequeue effect (a simultaneous id_ready_i handshake is void: the head is discarded, not delivered).
- id_valid_o = (count != 0). id_pc_o/id_inst_o = head entry when valid, 32'h0 when count = 0.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000, fetch continues.

## Timing
- Reset (rst=0): pc=RESET_PC, ce=0, count=0, pointers=0, halted=0; rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0, id_misalign_o=0.
- Reset release: ce sets at first rising edge after rst=1; first enqueue at second edge.
- Latency: instruction at address A visible on id_* one cycle after rom_addr_o=A (with ready held high: one instruction per cycle throughput).
- Redirect asserted in cycle N: rom_addr_o = target in cycle N+1; its instruction on id_* in cycle N+2; id_valid_o=0 in cycle N+1.
- Full (count=2) with id_ready_i=0: pc frozen, rom_addr_o stable, no enqueue.
- Reset mid-operation clears buffer immediately (asynchronous); no partial entries survive.

## Configuration
- FETCH_MISALIGN_EN defined: redirect target with [1:0] != 0 loads pc unchanged, then next enqueue-eligible cycle writes one entry {target, 32'h0, misalign=1} and sets halted=1; no further fetch until the next flush/branch clears halted. id_misalign_o reflects head entry.
- Undefined: redirect targets are forced to {target[31:2], 2'b00}; id_misalign_o tied 0; no halted register.

## Test plan
- Reset then ready=1, ROM words 0..3 = 3401FFFF, 00010C00, 3421FFFB, 34020006 -> id_pc_o 0,4,8,C on consecutive cycles with matching id_inst_o.
- Hold id_ready_i=0 five cycles -> count reaches 2, rom_addr_o stays 8, id_pc_o=0; release -> 0,4,8 delivered in order, none lost or duplicated.
- branch_flag_i with target 0x40 while count=2 and ready=1 -> both entries discarded, id_valid_o=0 next cycle, then id_pc_o=0x40.
- flush_i (flush_pc_i=0x100) and branch_flag_i (0x40) same cycle -> fetch resumes at 0x100.
- pc=0xFFFFFFFC -> next rom_addr_o=0x00000000, id_pc_o sequence FFFFFFFC, 0.
- Branch to 0x42: with FETCH_MISALIGN_EN -> one entry id_pc_o=0x42, id_misalign_o=1, fetch halts until next redirect; without -> fetch at 0x40.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: ROM address/data port plus the decode handshake.
// master = fetch stage, slave = ROM and decode side.
interface inst_fetch_if;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_misalign_o;

    modport master (
        output rom_ce_o,
        output rom_addr_o,
        input  rom_inst_i,
        input  branch_flag_i,
        input  branch_target_i,
        input  flush_i,
        input  flush_pc_i,
        output id_valid_o,
        input  id_ready_i,
        output id_pc_o,
        output id_inst_o,
        output id_misalign_o
    );

    modport slave (
        input  rom_ce_o,
        input  rom_addr_o,
        output rom_inst_i,
        output branch_flag_i,
        output branch_target_i,
        output flush_i,
        output flush_pc_i,
        input  id_valid_o,
        output id_ready_i,
        input  id_pc_o,
        input  id_inst_o,
        input  id_misalign_o
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: PC, ROM drive and 2-entry prefetch buffer toward decode.
// FETCH_MISALIGN_EN: misaligned redirects emit a marker entry and halt fetch.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } entry_t;

    entry_t      fifo [2];
    entry_t      head;
    logic [31:0] pc;
    logic        ce;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        halted;
    logic        redirect;
    logic        deq;
    logic        enq;
    logic        mis_fetch;
    logic [31:0] target;

    always_comb begin
        redirect = bus.flush_i || bus.branch_flag_i;
        target   = bus.flush_i ? bus.flush_pc_i
                                : bus.branch_target_i;
`ifndef FETCH_MISALIGN_EN
        target   = target & 32'hFFFF_FFFC;
`endif
        deq      = (count != 2'd0) && bus.id_ready_i;
        enq      = ce && !redirect && !halted
                   && ((count < 2'(BUF_DEPTH)) || deq);
    end

`ifdef FETCH_MISALIGN_EN
    assign mis_fetch = (pc[1:0] != 2'b00);
`else
    assign mis_fetch = 1'b0;
    assign halted    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            ce     <= 1'b0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
`ifdef FETCH_MISALIGN_EN
            halted <= 1'b0;
`endif
        end else begin
            ce <= 1'b1;
            if (redirect) begin
                // Redirect voids any same-cycle handshake
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                pc     <= target;
`ifdef FETCH_MISALIGN_EN
                halted <= 1'b0;
`endif
            end else begin
                if (deq) rd_ptr <= ~rd_ptr;
                if (enq) begin
                    wr_ptr <= ~wr_ptr;
                    if (mis_fetch) begin
                        fifo[wr_ptr] <= '{pc, 32'h0, 1'b1};
`ifdef FETCH_MISALIGN_EN
                        halted <= 1'b1;
`endif
                    end else begin
                        fifo[wr_ptr] <= '{pc, bus.rom_inst_i, 1'b0};
                        pc <= pc + 32'd4;
                    end
                end
                if (enq && !deq) count <= count + 2'd1;
                else if (deq && !enq) count <= count - 2'd1;
            end
        end
    end

    assign head              = fifo[rd_ptr];
    assign bus.rom_ce_o      = ce;
    assign bus.rom_addr_o    = pc;
    assign bus.id_valid_o    = (count != 2'd0);
    assign bus.id_pc_o       = bus.id_valid_o ? head.pc : 32'h0;
    assign bus.id_inst_o     = bus.id_valid_o ? head.inst : 32'h0;
    assign bus.id_misalign_o = bus.id_valid_o && head.misalign;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_inst_fetch;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    inst_fetch_if bus ();

    inst_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h3401_FFFF;
            32'h4:   return 32'h0001_0C00;
            32'h8:   return 32'h3421_FFFB;
            32'hC:   return 32'h3402_0006;
            default: return a ^ 32'h5A5A_1234;
        endcase
    endfunction

    assign bus.rom_inst_i = rom_fn(bus.rom_addr_o);

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_halt;

    // Model: fetched words queue up to two deep in program order
    always @(posedge clk) begin
        logic        had_ce;
        logic [31:0] tgt;
        ent_t        e;
        if (!rst) begin
            mq.delete();
            m_pc   = 32'h0;
            m_ce   = 1'b0;
            m_halt = 1'b0;
        end else begin
            had_ce = m_ce;
            m_ce   = 1'b1;
            if (bus.flush_i || bus.branch_flag_i) begin
                tgt = bus.flush_i ? bus.flush_pc_i
                                  : bus.branch_target_i;
`ifndef FETCH_MISALIGN_EN
                tgt[1:0] = 2'b00;
`endif
                mq.delete();
                m_pc   = tgt;
                m_halt = 1'b0;
            end else begin
                if (mq.size() > 0 && bus.id_ready_i)
                    void'(mq.pop_front());
                if (had_ce && !m_halt && mq.size() < 2) begin
                    if (m_pc[1:0] != 2'b00) begin
                        e.pc = m_pc; e.inst = 32'h0; e.mis = 1'b1;
                        mq.push_back(e);
                        m_halt = 1'b1;
                    end else begin
                        e.pc = m_pc; e.inst = rom_fn(m_pc); e.mis = 1'b0;
                        mq.push_back(e);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
        #1;
        chk("m_ce", 32'(bus.rom_ce_o), 32'(m_ce));
        chk("m_addr", bus.rom_addr_o, m_pc);
        chk("m_valid", 32'(bus.id_valid_o), 32'(mq.size() > 0));
        chk("m_pc", bus.id_pc_o,
            mq.size() > 0 ? mq[0].pc : 32'h0);
        chk("m_inst", bus.id_inst_o,
            mq.size() > 0 ? mq[0].inst : 32'h0);
        chk("m_mis", 32'(bus.id_misalign_o),
            32'(mq.size() > 0 && mq[0].mis));
    end

    task automatic redir(input logic fl, input logic [31:0] fpc,
                         input logic br, input logic [31:0] bt);
        bus.flush_i         = fl;
        bus.flush_pc_i      = fpc;
        bus.branch_flag_i   = br;
        bus.branch_target_i = bt;
        @(negedge clk);
        bus.flush_i       = 1'b0;
        bus.branch_flag_i = 1'b0;
    endtask

    logic [31:0] exp_pc [4];
    logic [31:0] exp_in [4];
    logic [19:0] rdy_pat;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_in = '{32'h3401_FFFF, 32'h0001_0C00,
                   32'h3421_FFFB, 32'h3402_0006};
        rdy_pat = 20'b1011_0011_1000_1101_0110;
        rst = 1'b0;
        bus.id_ready_i      = 1'b0;
        bus.flush_i         = 1'b0;
        bus.flush_pc_i      = 32'h0;
        bus.branch_flag_i   = 1'b0;
        bus.branch_target_i = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ce", 32'(bus.rom_ce_o), 32'h0);
        chk("rst_addr", bus.rom_addr_o, 32'h0);
        chk("rst_valid", 32'(bus.id_valid_o), 32'h0);
        chk("rst_pc", bus.id_pc_o, 32'h0);
        chk("rst_inst", bus.id_inst_o, 32'h0);
        chk("rst_mis", 32'(bus.id_misalign_o), 32'h0);

        rst = 1'b1;
        bus.id_ready_i = 1'b1;
        @(negedge clk);
        chk("rel_ce", 32'(bus.rom_ce_o), 32'h1);
        chk("rel_valid", 32'(bus.id_valid_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq_pc", bus.id_pc_o, exp_pc[i]);
            chk("seq_inst", bus.id_inst_o, exp_in[i]);
        end

        rst = 1'b0;
        bus.id_ready_i = 1'b0;
        #1;
        chk("async_clr", 32'(bus.id_valid_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("hold_addr", bus.rom_addr_o, 32'h8);
        chk("hold_pc", bus.id_pc_o, 32'h0);
        chk("hold_valid", 32'(bus.id_valid_o), 32'h1);
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("drain_pc", bus.id_pc_o, exp_pc[i]);
        end

        bus.id_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        bus.id_ready_i = 1'b1;
        redir(1'b0, 32'h0, 1'b1, 32'h40);
        chk("br_valid", 32'(bus.id_valid_o), 32'h0);
        chk("br_addr", bus.rom_addr_o, 32'h40);
        @(negedge clk);
        chk("br_pc", bus.id_pc_o, 32'h40);

        redir(1'b1, 32'h100, 1'b1, 32'h40);
        chk("fl_addr", bus.rom_addr_o, 32'h100);
        @(negedge clk);
        chk("fl_pc", bus.id_pc_o, 32'h100);

        redir(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr", bus.rom_addr_o, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_pc", bus.id_pc_o, 32'hFFFF_FFFC);
        chk("wrap_next", bus.rom_addr_o, 32'h0);
        @(negedge clk);
        chk("wrap_pc2", bus.id_pc_o, 32'h0);

        redir(1'b0, 32'h0, 1'b1, 32'h42);
`ifdef FETCH_MISALIGN_EN
        chk("mis_addr", bus.rom_addr_o, 32'h42);
        @(negedge clk);
        chk("mis_pc", bus.id_pc_o, 32'h42);
        chk("mis_flag", 32'(bus.id_misalign_o), 32'h1);
        repeat (3) @(negedge clk);
        chk("halt_valid", 32'(bus.id_valid_o), 32'h0);
        chk("halt_addr", bus.rom_addr_o, 32'h42);
`else
        chk("mis_addr", bus.rom_addr_o, 32'h40);
        @(negedge clk);
        chk("mis_pc", bus.id_pc_o, 32'h40);
        chk("mis_flag", 32'(bus.id_misalign_o), 32'h0);
        repeat (3) @(negedge clk);
`endif
        redir(1'b0, 32'h0, 1'b1, 32'h80);
        @(negedge clk);
        chk("resume_pc", bus.id_pc_o, 32'h80);

        for (int i = 0; i < 20; i++) begin
            bus.id_ready_i = rdy_pat[i];
            if (i == 11) redir(1'b1, 32'h200, 1'b0, 32'h0);
            else @(negedge clk);
        end
        bus.id_ready_i = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
